// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares one level-sensitive data memory between two requesters. A winning
//   request is latched in IDLE and then played out to the memory in a fixed
//   order. The address and data settle in SETUP. The strobe pulses in STROBE.
//   The strobe is released in HOLD while the address is still held. The
//   requester is told it is finished in RESP. Every output is a flop, so the
//   memory strobes cannot glitch.
//
// Build option:
//   DMEM_ARB_RR_EN  defined   -> round-robin between the two ports
//                   undefined -> fixed priority, port 0 wins every tie
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous reset, active low (0 = in reset)
//   pN_req/we/addr/wdata  request from port N, held until pN_gnt
//   pN_gnt              one-cycle pulse when the request is accepted
//   pN_done             one-cycle pulse when the access is complete
//   pN_rdata            read data, valid from pN_done until the next read
//   mem_wr/mem_rd       memory write and read strobes (memWr/memRd)
//   mem_addr/mem_wdata  memory address and write data (Address_/Data_input)
//   mem_rdata           memory read data (Data_output)
//   busy                high whenever the sequencer is not in IDLE
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              mem_wr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SETUP  = 3'd1;
    localparam logic [2:0] STROBE = 3'd2;
    localparam logic [2:0] HOLD   = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              win_q, win_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pick1;

    logic              p0_gnt_q, p1_gnt_q, p0_done_q, p1_done_q;
    logic              mem_wr_q, mem_rd_q, busy_q;
    logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

    // Port 1 wins when it is the only requester. When both ports request,
    // the build option decides who wins.
`ifdef DMEM_ARB_RR_EN
    logic last_grant_q;

    always_comb begin
        pick1 = p1_req && (!p0_req || !last_grant_q);
    end

    // last_grant records the winner of the most recent grant.
    // It resets to 1 so that port 0 is favoured first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else if (state_q == IDLE && state_d == SETUP) begin
            last_grant_q <= win_d;
        end
    end
`else
    always_comb begin
        pick1 = p1_req && !p0_req;
    end
`endif

    // The latch registers (win/we/addr/wdata) are loaded only when leaving
    // IDLE. Input changes during an access therefore cannot reach the memory.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (p0_req || p1_req) begin
                    state_d = SETUP;
                    win_d   = pick1;
                    we_d    = pick1 ? p1_we    : p0_we;
                    addr_d  = pick1 ? p1_addr  : p0_addr;
                    wdata_d = pick1 ? p1_wdata : p0_wdata;
                end
            end
            SETUP:   state_d = STROBE;
            STROBE:  state_d = HOLD;
            HOLD:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The outputs are decoded from the next state and registered. They
    // therefore change on the same edge as the state and never glitch.
    // Reset clears the strobes asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            win_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            p0_gnt_q   <= 1'b0;
            p1_gnt_q   <= 1'b0;
            p0_done_q  <= 1'b0;
            p1_done_q  <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            p0_gnt_q  <= (state_q == IDLE) && (state_d == SETUP) && !win_d;
            p1_gnt_q  <= (state_q == IDLE) && (state_d == SETUP) && win_d;
            mem_wr_q  <= (state_d == STROBE) && we_q;
            mem_rd_q  <= (state_d == STROBE) && !we_q;
            p0_done_q <= (state_d == RESP) && !win_q;
            p1_done_q <= (state_d == RESP) && win_q;
            busy_q    <= (state_d != IDLE);
            // The memory output is still driven during HOLD because the
            // address is held. It is sampled at the end of HOLD.
            if (state_q == HOLD && !we_q) begin
                if (win_q) begin
                    p1_rdata_q <= mem_rdata;
                end else begin
                    p0_rdata_q <= mem_rdata;
                end
            end
        end
    end

    assign p0_gnt    = p0_gnt_q;
    assign p1_gnt    = p1_gnt_q;
    assign p0_done   = p0_done_q;
    assign p1_done   = p1_done_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign mem_wr    = mem_wr_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_port_arbiter
//
// Purpose:
//   Directed bench for dmem_port_arbiter. A table of single-port
//   transactions is walked cycle by cycle. Hand-written sequences then cover
//   a reset in the middle of an access, a withdrawn request and two ports
//   contending for the memory. The memory model is level-strobed: it writes
//   on mem_wr and latches read data on mem_rd.
// ---------------------------------------------------------------------------
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [9:0]  p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_done, p1_gnt, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_wr, mem_rd, busy;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, memDout;
    logic [31:0] mem [1024];

    int vectors = 0;
    int miscompares = 0;

    dmem_port_arbiter #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(memDout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model. Words 4 and 5 are preloaded while reset is low, so that
    // the contention test has known data to read.
    always @(posedge clk) begin
        if (!reset) begin
            mem[4] <= 32'd100;
            mem[5] <= 32'd200;
        end else begin
            if (mem_wr) mem[mem_addr] <= mem_wdata;
            if (mem_rd) memDout <= mem[mem_addr];
        end
    end

    typedef struct {
        logic        port;
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] expRd;
        logic [31:0] expOther;
    } vec_t;

    vec_t vecs [7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic port, input logic req, input logic we,
                                 input logic [9:0] addr, input logic [31:0] wdata);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end else begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end
    endtask

    // Runs one transaction, starting from IDLE, and checks every cycle.
    // After the grant the request lines are scrambled, so the access must
    // complete from the values latched in IDLE.
    task automatic runTxn(input vec_t v);
        logic gW, gO, dW, dO;
        logic [31:0] rW, rO;
        applyStimulus(v.port, 1'b1, v.we, v.addr, v.wdata);
        step();
        gW = v.port ? p1_gnt : p0_gnt;
        gO = v.port ? p0_gnt : p1_gnt;
        checkOutput("gnt_win", {31'd0, gW}, 32'd1);
        checkOutput("gnt_other", {31'd0, gO}, 32'd0);
        checkOutput("setup_strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
        checkOutput("setup_addr", {22'd0, mem_addr}, {22'd0, v.addr});
        checkOutput("setup_busy", {31'd0, busy}, 32'd1);
        applyStimulus(v.port, 1'b0, ~v.we, ~v.addr, ~v.wdata);
        step();
        checkOutput("strobe_wr", {31'd0, mem_wr}, {31'd0, v.we});
        checkOutput("strobe_rd", {31'd0, mem_rd}, {31'd0, !v.we});
        checkOutput("strobe_addr", {22'd0, mem_addr}, {22'd0, v.addr});
        if (v.we) checkOutput("strobe_wdata", mem_wdata, v.wdata);
        step();
        checkOutput("hold_strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
        checkOutput("hold_addr", {22'd0, mem_addr}, {22'd0, v.addr});
        step();
        dW = v.port ? p1_done : p0_done;
        dO = v.port ? p0_done : p1_done;
        rW = v.port ? p1_rdata : p0_rdata;
        rO = v.port ? p0_rdata : p1_rdata;
        checkOutput("done_win", {31'd0, dW}, 32'd1);
        checkOutput("done_other", {31'd0, dO}, 32'd0);
        checkOutput("resp_strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
        if (!v.we) checkOutput("rdata_win", rW, v.expRd);
        checkOutput("rdata_other", rO, v.expOther);
        step();
        checkOutput("idle_busy", {31'd0, busy}, 32'd0);
        checkOutput("idle_done", {30'd0, p0_done, p1_done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 10'd7,    32'd42,         32'd0,          32'd0};
        vecs[1] = '{1'b1, 1'b0, 10'd7,    32'd0,          32'd42,         32'd0};
        vecs[2] = '{1'b0, 1'b1, 10'h3FF,  32'hFFFFFFFF,   32'd0,          32'd42};
        vecs[3] = '{1'b0, 1'b0, 10'h3FF,  32'd0,          32'hFFFFFFFF,   32'd42};
        vecs[4] = '{1'b1, 1'b1, 10'd0,    32'h12345678,   32'd0,          32'hFFFFFFFF};
        vecs[5] = '{1'b1, 1'b0, 10'd0,    32'd0,          32'h12345678,   32'hFFFFFFFF};
        vecs[6] = '{1'b0, 1'b0, 10'd7,    32'd0,          32'd42,         32'h12345678};

        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd0, 32'd0);
        step();
        step();
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_pulses", {28'd0, p0_gnt, p1_gnt, p0_done, p1_done}, 32'd0);
        checkOutput("reset_strobes", {30'd0, mem_wr, mem_rd}, 32'd0);
        checkOutput("reset_addr", {22'd0, mem_addr}, 32'd0);
        checkOutput("reset_wdata", mem_wdata, 32'd0);
        checkOutput("reset_rdata0", p0_rdata, 32'd0);
        checkOutput("reset_rdata1", p1_rdata, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) runTxn(vecs[i]);

        // Port 1 pulses its request while port 0 is in HOLD. The request is
        // withdrawn before IDLE, so port 1 must never be granted.
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd7, 32'd0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 10'd7, 32'd0);
        step();
        step();
        applyStimulus(1'b1, 1'b1, 1'b0, 10'd5, 32'd0);
        step();
        applyStimulus(1'b1, 1'b0, 1'b0, 10'd5, 32'd0);
        checkOutput("drop_p0_done", {31'd0, p0_done}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            step();
            checkOutput("drop_no_gnt", {30'd0, p0_gnt, p1_gnt}, 32'd0);
            checkOutput("drop_idle", {31'd0, busy}, 32'd0);
        end

        // A port 0 write is interrupted by reset during STROBE. The strobe
        // must fall without a clock edge.
        applyStimulus(1'b0, 1'b1, 1'b1, 10'd9, 32'd55);
        step();
        applyStimulus(1'b0, 1'b0, 1'b1, 10'd9, 32'd55);
        step();
        checkOutput("rst_pre_wr", {31'd0, mem_wr}, 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_async_wr", {31'd0, mem_wr}, 32'd0);
        checkOutput("rst_async_busy", {31'd0, busy}, 32'd0);
        step();
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput("rst_no_done", {30'd0, p0_done, p1_done}, 32'd0);
        end
        runTxn('{1'b1, 1'b0, 10'd7, 32'd0, 32'd42, 32'd0});

        // Both ports hold read requests. Grants land every 5 cycles:
        // round-robin alternates p0, p1, p0; fixed priority serves p0 only.
        applyStimulus(1'b0, 1'b1, 1'b0, 10'd4, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 10'd5, 32'd0);
        for (int c = 1; c <= 15; c++) begin
            logic e0, e1;
            step();
            e0 = (c == 1) || (c == 11) || (!RR && c == 6);
            e1 = RR && (c == 6);
            checkOutput($sformatf("both_gnt_c%0d", c), {30'd0, p0_gnt, p1_gnt}, {30'd0, e0, e1});
            if (c == 5) checkOutput("both_rdata0", p0_rdata, 32'd100);
            if (c == 10 && RR) checkOutput("both_rdata1", p1_rdata, 32'd200);
            if (c == 11) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 10'd4, 32'd0);
                applyStimulus(1'b1, 1'b0, 1'b0, 10'd5, 32'd0);
            end
        end
        checkOutput("both_end_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
Two-port sequencer that shares the single 1024x32 data memory between requesters, such as the load/store stage and a debug/DMA port. It arbitrates, latches the winning request and drives the memory's level-sensitive strobes (memWr/memRd, Address_, Data_input) in a fixed, glitch-free order. Read data from Data_output is returned to the winner with a one-cycle done pulse. It sits between the requesters and the data memory and is the only driver of the memory's control inputs.

Parameters:
ADDR_W, 10, address width (memory depth 2^ADDR_W words)
DATA_W, 32, data width (signed, passed through unmodified)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
p0_req  input  1  port 0 request; held until p0_gnt
p0_we  input  1  port 0: 1 = write, 0 = read
p0_addr  input  ADDR_W  port 0 word address
p0_wdata  input  DATA_W  port 0 write data
p0_gnt  output  1  one-cycle pulse: port 0 request accepted
p0_done  output  1  one-cycle pulse: port 0 access complete
p0_rdata  output  DATA_W  port 0 read data, valid from p0_done
p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata  same as port 0, for port 1
mem_wr  output  1  to memWr
mem_rd  output  1  to memRd
mem_addr  output  ADDR_W  to Address_
mem_wdata  output  DATA_W  to Data_input
mem_rdata  input  DATA_W  from Data_output
busy  output  1  high in any state other than IDLE

Behaviour:
- All outputs are registered.
- Reset (reset=0, async):
  - state=IDLE; all gnt, done, strobe and busy outputs 0.
  - mem_addr, mem_wdata and both rdata registers 0.
  - Arbitration pointer: last_grant=1, so port 0 is favoured first.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> RESP -> IDLE.
  - IDLE: sample req lines. If any is high, pick the winner, latch its we/addr/wdata and go to SETUP. Otherwise stay.
  - SETUP: winner's gnt=1 (single cycle). mem_addr/mem_wdata driven from the latch. Strobes 0, so the address is stable before the strobe edge.
  - STROBE: exactly one of mem_wr/mem_rd=1 for exactly one cycle. Address and data are held.
  - HOLD: strobes 0, address held. For a read, capture mem_rdata into the winner's rdata register at the end of the cycle.
  - RESP: winner's done=1 (single cycle). rdata is valid and holds until that port's next read completes. The other port's rdata is untouched.
- Latency: req sampled in cycle 0 -> gnt in cycle 1 -> strobe in cycle 2 -> done in cycle 4. Minimum period between accesses is 5 cycles.
- mem_wr and mem_rd are never high together, and never high outside STROBE.
- A req still high in the IDLE cycle after done counts as a new request.
- A req dropped before gnt is a withdrawn request; a req dropped after gnt is ignored, because the access completes from the latch.
- Inputs that change after IDLE do not affect the access in flight.
- Full address range 0..2^ADDR_W-1 is legal; there is no wrap or range check. Data passes through bit-exact.
- Reset asserted mid-access (any state): strobes drop immediately, no done is issued, the memory write may or may not have occurred, and the FSM returns to IDLE.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin. When both ports request in IDLE, the port not equal to last_grant wins; last_grant updates on every grant. A single requester always wins.
- Undefined: fixed priority. Port 0 wins every tie, last_grant is unused, and port 1 can starve while p0_req stays high.

Test Plan:
1. Release reset; p0 write addr 7, data 42 -> p0_gnt in cycle 1; mem_wr=1 in cycle 2 only, with mem_addr=7 and mem_wdata=42; p0_done in cycle 4; mem_rd stays 0 throughout.
2. Then p1 read addr 7 -> mem_rd single pulse with mem_addr=7; p1_rdata=42 in the p1_done cycle; p0_rdata unchanged.
3. With DMEM_ARB_RR_EN, p0 and p1 both read (addr 4 and addr 5) simultaneously, held -> p0 is served first, p1 second. With both held, grants alternate p0, p1, p0, and gnt pulses are 5 cycles apart. Without the macro: only p0 is granted while p0_req stays high.
4. Assert reset during STROBE of a write -> mem_wr falls without a clock edge; no done; busy=0; after release, a new p1 request is granted normally.
5. p0 write addr 1023, data -1, then read addr 1023 -> mem_addr=10'h3FF; p0_rdata=32'hFFFFFFFF.
6. p1_req pulsed for one cycle while p0's access is in HOLD, then dropped -> no p1_gnt; FSM returns to IDLE after p0_done and stays there.
